fios_top_control: RTL and testbench
===================================

Name: fios_top_control

Overview:
- Top-level sequencer for one Montgomery multiplication run.
- On a host start it runs three phases in order: operand load (memory FSM), FIOS compute, result store (memory FSM). It then reports completion to the host.
- Owns the start/load_store handshake into the memory FSM, the start/done handshake with the FIOS core, and BRAM ownership between host and core.
- Adds a per-phase watchdog with a sticky error flag.

Parameters:
- s, 16, number of 17-bit limbs per operand; sets the default watchdog bound.
- TIMEOUT_CYCLES, 64*s, maximum cycles allowed in any single wait state before error; must be >= 3*s+8.

Ports:
- clock_i  in  1  system clock, all state on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  host start pulse; sampled only in IDLE, DONE, ERROR.
- busy_o  out  1  high from first cycle after accepted start until DONE/ERROR entered.
- done_o  out  1  sticky completion flag; cleared by next accepted start.
- error_o  out  1  sticky watchdog error; cleared by next accepted start.
- err_phase_o  out  2  phase that timed out: 1 load, 2 compute, 3 store; 0 otherwise.
- host_bram_sel_o  out  1  1 = host owns BRAM port (IDLE/DONE/ERROR), 0 = core.
- mem_start_o  out  1  one-cycle start pulse to memory FSM.
- mem_load_store_o  out  1  0 = load, 1 = store; valid with mem_start_o, held for whole phase.
- mem_load_done_i  in  1  one-cycle pulse from memory FSM at end of load.
- mem_store_done_i  in  1  one-cycle pulse from memory FSM at end of store.
- fios_start_o  out  1  one-cycle start pulse to FIOS core.
- fios_done_i  in  1  one-cycle pulse from FIOS core when result register is valid.

Behaviour:
- Reset (reset_ni=0, async): state=IDLE, watchdog=0. Outputs: busy_o=0, done_o=0, error_o=0, err_phase_o=0, host_bram_sel_o=1, mem_start_o=0, mem_load_store_o=0, fios_start_o=0. Reset deassertion mid-operation always restarts from IDLE; no phase resumes.
- States: IDLE, LOAD_REQ, LOAD_WAIT, COMP_REQ, COMP_WAIT, STORE_REQ, STORE_WAIT, DONE, ERROR. Encoding constants live in the package.
- Transitions:
  - IDLE/DONE/ERROR -> LOAD_REQ on start_i=1. Same edge clears done_o, error_o and err_phase_o.
  - LOAD_REQ -> LOAD_WAIT unconditionally. mem_start_o=1 and mem_load_store_o=0 for exactly this cycle.
  - LOAD_WAIT -> COMP_REQ on mem_load_done_i.
  - COMP_REQ -> COMP_WAIT unconditionally. fios_start_o=1 this cycle.
  - COMP_WAIT -> STORE_REQ on fios_done_i.
  - STORE_REQ -> STORE_WAIT unconditionally. mem_start_o=1 and mem_load_store_o=1. mem_load_store_o stays 1 through STORE_WAIT.
  - STORE_WAIT -> DONE on mem_store_done_i. done_o is set on entry.
- All outputs are registered (Moore). A pulse appears the cycle after the state is entered; mem_start_o and fios_start_o are never high for more than one cycle.
- host_bram_sel_o=0 in all REQ/WAIT states and 1 otherwise. It switches to 0 one cycle before mem_start_o is first asserted.
- Latency with zero-delay responders: start_i accepted at edge N -> done_o=1 at edge N+7.
- Watchdog:
  - Counts cycles spent in each WAIT state and is cleared on every state change.
  - When it reaches TIMEOUT_CYCLES-1 and the expected done pulse is still absent, move to ERROR: set error_o=1 and err_phase_o to the phase; done_o stays 0.
  - If the done pulse and the timeout occur in the same cycle, the done pulse wins.
- Stray done pulses (any *_done_i outside its matching WAIT state) are ignored and raise no error.
- start_i while busy_o=1 is ignored; no queuing.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.

Decomposition:
- Shared package fios_ctrl_pkg:
  - state typedef/encodings
  - phase codes PH_NONE/PH_LOAD/PH_COMP/PH_STORE
  - default TIMEOUT function of s
- One natural sub-module: phase_watchdog, a saturating counter with clear, enable and terminal-count output.
- Everything else is a single FSM in fios_top_control.

Test Plan:
- s=4, TIMEOUT=64. Pulse start_i. Respond to mem_start_o with load_done after 14 cycles, to fios_start_o with fios_done after 20, store_done after 5. Required: exactly two mem_start_o pulses (load_store 0 then 1), one fios_start_o, done_o=1, busy_o=0, host_bram_sel_o=1.
- Zero-delay responders (done pulse the cycle after each start). Required: done_o rises exactly 7 edges after start_i is sampled.
- FIOS never responds. Required: ERROR entered 64 cycles after COMP_WAIT entry, error_o=1, err_phase_o=2, no store start issued.
- fios_done_i pulse on the exact timeout cycle. Required: proceeds to STORE_REQ, error_o stays 0.
- start_i re-pulsed during LOAD_WAIT and mem_store_done_i pulsed in COMP_WAIT. Required: both ignored, sequence completes normally; a later start clears done_o on the acceptance edge.
- reset_ni low for 1 cycle during STORE_WAIT. Required: all outputs return to reset values immediately (asynchronous); the next start_i runs a full load-compute-store sequence.

Source files
------------

// File: rtl/fios_ctrl_pkg.sv
// Shared types and constants for the Montgomery run sequencer.
// Holds state encodings, phase codes and the default watchdog bound.
package fios_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_LOAD_REQ   = 4'd1,
      ST_LOAD_WAIT  = 4'd2,
      ST_COMP_REQ   = 4'd3,
      ST_COMP_WAIT  = 4'd4,
      ST_STORE_REQ  = 4'd5,
      ST_STORE_WAIT = 4'd6,
      ST_DONE       = 4'd7,
      ST_ERROR      = 4'd8
   } ctrl_state_e;

   localparam logic [1:0] PH_NONE  = 2'd0;
   localparam logic [1:0] PH_LOAD  = 2'd1;
   localparam logic [1:0] PH_COMP  = 2'd2;
   localparam logic [1:0] PH_STORE = 2'd3;

   function automatic int default_timeout(input int s);
      return 64 * s;
   endfunction

   // Core owns the BRAM and the run counts as busy in every REQ/WAIT state.
   function automatic logic is_active(input ctrl_state_e st);
      return (st == ST_LOAD_REQ)  || (st == ST_LOAD_WAIT) ||
             (st == ST_COMP_REQ)  || (st == ST_COMP_WAIT) ||
             (st == ST_STORE_REQ) || (st == ST_STORE_WAIT);
   endfunction

   function automatic logic is_wait(input ctrl_state_e st);
      return (st == ST_LOAD_WAIT) || (st == ST_COMP_WAIT) || (st == ST_STORE_WAIT);
   endfunction

endpackage

// File: rtl/fios_top_control_watchdog.sv
// Saturating per-phase cycle counter with synchronous clear.
// tc_o flags the last permitted cycle of a wait while counting is enabled.
module phase_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT_CYCLES);
   localparam logic [W-1:0] TC_VAL  = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q >= TC_VAL);

endmodule

// File: rtl/fios_top_control.sv
// Sequencer for one Montgomery run: load, FIOS compute, store, then report.
// All host/core-facing outputs are registered; start pulses trail their REQ state by one cycle.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   IDLE       | host owns BRAM, waiting for start
//   LOAD_REQ   | issue load request to memory FSM
//   LOAD_WAIT  | waiting for mem_load_done_i
//   COMP_REQ   | issue start to FIOS core
//   COMP_WAIT  | waiting for fios_done_i
//   STORE_REQ  | issue store request to memory FSM
//   STORE_WAIT | waiting for mem_store_done_i
//   DONE       | run complete, done_o sticky
//   ERROR      | a wait timed out, error_o/err_phase_o sticky
module fios_top_control
   import fios_ctrl_pkg::*;
#(
   parameter int s              = 16,
   parameter int TIMEOUT_CYCLES = default_timeout(s)
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [1:0] err_phase_o,
   output logic       host_bram_sel_o,
   output logic       mem_start_o,
   output logic       mem_load_store_o,
   input  logic       mem_load_done_i,
   input  logic       mem_store_done_i,
   output logic       fios_start_o,
   input  logic       fios_done_i
);

   ctrl_state_e state_q, state_d;
   logic [1:0]  tmo_phase_q, tmo_phase_d;
   logic        accept;
   logic        wd_tc;
   logic        wd_clr;
   logic        wd_en;

   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic [1:0] err_phase_q, err_phase_d;
   logic       host_sel_q, host_sel_d;
   logic       mem_start_q, mem_start_d;
   logic       mem_ls_q, mem_ls_d;
   logic       fios_start_q, fios_start_d;

   assign wd_en  = is_wait(state_q);
   assign wd_clr = (state_d != state_q) || !wd_en;

   phase_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .tc_o     (wd_tc)
   );

   always_comb begin
      state_d     = state_q;
      tmo_phase_d = tmo_phase_q;
      accept      = 1'b0;

      // In each wait the done pulse is tested before the watchdog so it wins a tie.
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               state_d     = ST_LOAD_REQ;
               tmo_phase_d = PH_NONE;
               accept      = 1'b1;
            end
         end
         ST_LOAD_REQ:  state_d = ST_LOAD_WAIT;
         ST_LOAD_WAIT: begin
            if (mem_load_done_i) begin
               state_d = ST_COMP_REQ;
            end else if (wd_tc) begin
               state_d     = ST_ERROR;
               tmo_phase_d = PH_LOAD;
            end
         end
         ST_COMP_REQ:  state_d = ST_COMP_WAIT;
         ST_COMP_WAIT: begin
            if (fios_done_i) begin
               state_d = ST_STORE_REQ;
            end else if (wd_tc) begin
               state_d     = ST_ERROR;
               tmo_phase_d = PH_COMP;
            end
         end
         ST_STORE_REQ: state_d = ST_STORE_WAIT;
         ST_STORE_WAIT: begin
            if (mem_store_done_i) begin
               state_d = ST_DONE;
            end else if (wd_tc) begin
               state_d     = ST_ERROR;
               tmo_phase_d = PH_STORE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d       = is_active(state_d);
      host_sel_d   = !is_active(state_d);
      mem_start_d  = (state_q == ST_LOAD_REQ) || (state_q == ST_STORE_REQ);
      mem_ls_d     = (state_q == ST_STORE_REQ) || (state_q == ST_STORE_WAIT);
      fios_start_d = (state_q == ST_COMP_REQ);

      done_d      = done_q;
      error_d     = error_q;
      err_phase_d = err_phase_q;
      if (accept) begin
         done_d      = 1'b0;
         error_d     = 1'b0;
         err_phase_d = PH_NONE;
      end else if (state_q == ST_DONE) begin
         done_d = 1'b1;
      end else if (state_q == ST_ERROR) begin
         error_d     = 1'b1;
         err_phase_d = tmo_phase_q;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         tmo_phase_q  <= PH_NONE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_phase_q  <= PH_NONE;
         host_sel_q   <= 1'b1;
         mem_start_q  <= 1'b0;
         mem_ls_q     <= 1'b0;
         fios_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_phase_q  <= tmo_phase_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_phase_q  <= err_phase_d;
         host_sel_q   <= host_sel_d;
         mem_start_q  <= mem_start_d;
         mem_ls_q     <= mem_ls_d;
         fios_start_q <= fios_start_d;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign error_o          = error_q;
   assign err_phase_o      = err_phase_q;
   assign host_bram_sel_o  = host_sel_q;
   assign mem_start_o      = mem_start_q;
   assign mem_load_store_o = mem_ls_q;
   assign fios_start_o     = fios_start_q;

endmodule

// File: tb/tb_fios_top_control.sv
// Self-checking bench for fios_top_control with delay-programmable responders.
// Expected timing comes from a per-phase arithmetic model of the run.
module tb_fios_top_control;

   localparam int S   = 4;
   localparam int TMO = 64;

   logic       clock_i = 1'b0;
   logic       reset_ni = 1'b0;
   logic       start_i = 1'b0;
   logic       busy_o, done_o, error_o, host_bram_sel_o;
   logic [1:0] err_phase_o;
   logic       mem_start_o, mem_load_store_o, fios_start_o;
   logic       mem_load_done_i, mem_store_done_i, fios_done_i;

   logic rsp_load = 1'b0, rsp_store = 1'b0, rsp_fios = 1'b0, stray_store = 1'b0;
   assign mem_load_done_i  = rsp_load;
   assign mem_store_done_i = rsp_store | stray_store;
   assign fios_done_i      = rsp_fios;

   int dl = 1, dc = 1, ds = 1;
   int cyc = 0;
   int checks = 0, errors = 0;

   fios_top_control #(.s(S), .TIMEOUT_CYCLES(TMO)) dut (
      .clock_i          (clock_i),
      .reset_ni         (reset_ni),
      .start_i          (start_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .error_o          (error_o),
      .err_phase_o      (err_phase_o),
      .host_bram_sel_o  (host_bram_sel_o),
      .mem_start_o      (mem_start_o),
      .mem_load_store_o (mem_load_store_o),
      .mem_load_done_i  (mem_load_done_i),
      .mem_store_done_i (mem_store_done_i),
      .fios_start_o     (fios_start_o),
      .fios_done_i      (fios_done_i)
   );

   always #5 clock_i = ~clock_i;
   always @(posedge clock_i) cyc <= cyc + 1;

   // Memory responder: delay d means the done pulse is sampled d edges after mem_start_o rises; 0 = never.
   initial begin : rsp_mem
      int  d;
      logic st;
      forever begin
         @(negedge clock_i);
         if (mem_start_o) begin
            st = mem_load_store_o;
            d  = st ? ds : dl;
            if (d > 0) begin
               repeat (d - 1) @(negedge clock_i);
               if (st) rsp_store = 1'b1; else rsp_load = 1'b1;
               @(negedge clock_i);
               rsp_load  = 1'b0;
               rsp_store = 1'b0;
            end
         end
      end
   end

   initial begin : rsp_core
      int d;
      forever begin
         @(negedge clock_i);
         if (fios_start_o) begin
            d = dc;
            if (d > 0) begin
               repeat (d - 1) @(negedge clock_i);
               rsp_fios = 1'b1;
               @(negedge clock_i);
               rsp_fios = 1'b0;
            end
         end
      end
   end

   int n_mem = 0, n_st = 0, n_fios = 0, n_long = 0, n_hs = 0;
   logic prev_mem = 1'b0, prev_fios = 1'b0, prev_sel = 1'b1;
   logic [1:0] ls_hist = 2'b00;

   always @(negedge clock_i) begin
      if (mem_start_o) begin
         n_mem   <= n_mem + 1;
         ls_hist <= {ls_hist[0], mem_load_store_o};
         if (mem_load_store_o) n_st <= n_st + 1;
         if (prev_sel || host_bram_sel_o) n_hs <= n_hs + 1;
      end
      if (fios_start_o) n_fios <= n_fios + 1;
      if ((mem_start_o && prev_mem) || (fios_start_o && prev_fios)) n_long <= n_long + 1;
      prev_mem  <= mem_start_o;
      prev_fios <= fios_start_o;
      prev_sel  <= host_bram_sel_o;
   end

   // Reference model: phases chain, each wait lasting its responder delay unless it exceeds the bound.
   function automatic void predict(input int n0, input int l, input int c, input int st,
                                   output int t_exp, output logic e_err, output int e_ph,
                                   output int e_mem, output int e_fios);
      int w;
      w = n0 + 1; e_err = 1'b0; e_ph = 0; e_mem = 1; e_fios = 0;
      if (l == 0 || l > TMO) begin
         e_err = 1'b1; e_ph = 1; t_exp = w + TMO + 1; return;
      end
      w = w + l + 1; e_fios = 1;
      if (c == 0 || c > TMO) begin
         e_err = 1'b1; e_ph = 2; t_exp = w + TMO + 1; return;
      end
      w = w + c + 1; e_mem = 2;
      if (st == 0 || st > TMO) begin
         e_err = 1'b1; e_ph = 3; t_exp = w + TMO + 1; return;
      end
      t_exp = w + st + 1;
   endfunction

   task automatic pulse_start(output int n0);
      @(negedge clock_i); start_i = 1'b1;
      @(negedge clock_i); start_i = 1'b0;
      n0 = cyc;
   endtask

   task automatic wait_end(output int t_end, output int t_busy);
      t_end = -1; t_busy = -1;
      for (int i = 0; i < 400; i++) begin
         if (!busy_o && t_busy < 0) t_busy = cyc;
         if (done_o || error_o) begin
            t_end = cyc;
            break;
         end
         @(negedge clock_i);
      end
      checks++;
      if (t_end < 0) begin
         errors++;
         $display("FAIL run_timeout: no done/error after 400 cycles, want completion");
      end
   endtask

   task automatic test_reset;
      checks += 8;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
      if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
      if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error_o); end
      if (err_phase_o !== 2'd0) begin errors++; $display("FAIL rst_phase: got %0d want 0", err_phase_o); end
      if (host_bram_sel_o !== 1'b1) begin errors++; $display("FAIL rst_hostsel: got %b want 1", host_bram_sel_o); end
      if (mem_start_o !== 1'b0) begin errors++; $display("FAIL rst_memstart: got %b want 0", mem_start_o); end
      if (mem_load_store_o !== 1'b0) begin errors++; $display("FAIL rst_ls: got %b want 0", mem_load_store_o); end
      if (fios_start_o !== 1'b0) begin errors++; $display("FAIL rst_fiosstart: got %b want 0", fios_start_o); end
   endtask

   task automatic test_nominal;
      int n0, t_end, t_busy, t_exp, e_ph, e_mem, e_fios, m0, f0, lg0, hs0;
      logic e_err;
      m0 = n_mem; f0 = n_fios; lg0 = n_long; hs0 = n_hs;
      dl = 14; dc = 20; ds = 5;
      pulse_start(n0);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL nom_busy_early: got %b want 1", busy_o); end
      wait_end(t_end, t_busy);
      predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
      repeat (3) @(negedge clock_i);
      checks += 9;
      if (t_end !== t_exp) begin errors++; $display("FAIL nom_latency: got %0d want %0d", t_end - n0, t_exp - n0); end
      if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL nom_flags: got done=%b err=%b want 1/0", done_o, error_o); end
      if (n_mem - m0 != 2) begin errors++; $display("FAIL nom_mem_pulses: got %0d want 2", n_mem - m0); end
      if (ls_hist !== 2'b01) begin errors++; $display("FAIL nom_ls_order: got %b want 01", ls_hist); end
      if (n_fios - f0 != 1) begin errors++; $display("FAIL nom_fios_pulses: got %0d want 1", n_fios - f0); end
      if (n_long != lg0) begin errors++; $display("FAIL nom_pulse_width: got %0d long pulses want 0", n_long - lg0); end
      if (n_hs != hs0) begin errors++; $display("FAIL nom_bram_handover: got %0d bad handovers want 0", n_hs - hs0); end
      if (busy_o !== 1'b0 || host_bram_sel_o !== 1'b1) begin errors++; $display("FAIL nom_idle_out: got busy=%b sel=%b want 0/1", busy_o, host_bram_sel_o); end
      if (t_busy !== t_exp - 1) begin errors++; $display("FAIL nom_busy_fall: got %0d want %0d", t_busy - n0, t_exp - 1 - n0); end
      repeat (80) @(negedge clock_i);
   endtask

   task automatic test_zero_latency;
      int n0, t_end, t_busy;
      dl = 1; dc = 1; ds = 1;
      pulse_start(n0);
      wait_end(t_end, t_busy);
      checks += 2;
      if (t_end - n0 != 7) begin errors++; $display("FAIL zero_latency: got %0d edges want 7", t_end - n0); end
      if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done_o); end
      repeat (80) @(negedge clock_i);
   endtask

   task automatic test_compute_timeout;
      int n0, t_end, t_busy, t_exp, e_ph, e_mem, e_fios, s0;
      logic e_err;
      s0 = n_st;
      dl = 3; dc = 0; ds = 2;
      pulse_start(n0);
      wait_end(t_end, t_busy);
      predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
      repeat (3) @(negedge clock_i);
      checks += 5;
      if (t_busy !== t_exp - 1) begin errors++; $display("FAIL tmo_entry: got %0d want %0d", t_busy - n0, t_exp - 1 - n0); end
      if (error_o !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error_o); end
      if (err_phase_o !== 2'd2) begin errors++; $display("FAIL tmo_phase: got %0d want 2", err_phase_o); end
      if (done_o !== 1'b0) begin errors++; $display("FAIL tmo_done: got %b want 0", done_o); end
      if (n_st != s0) begin errors++; $display("FAIL tmo_no_store: got %0d store starts want 0", n_st - s0); end
      repeat (10) @(negedge clock_i);
   endtask

   task automatic test_timeout_edge;
      int n0, t_end, t_busy, t_exp, e_ph, e_mem, e_fios;
      logic e_err;
      dl = 2; dc = TMO; ds = 2;
      pulse_start(n0);
      wait_end(t_end, t_busy);
      predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
      checks += 3;
      if (error_o !== 1'b0) begin errors++; $display("FAIL edge_error: got %b want 0", error_o); end
      if (done_o !== 1'b1) begin errors++; $display("FAIL edge_done: got %b want 1", done_o); end
      if (t_end !== t_exp) begin errors++; $display("FAIL edge_latency: got %0d want %0d", t_end - n0, t_exp - n0); end
      repeat (80) @(negedge clock_i);
   endtask

   task automatic test_stray;
      int n0, n1, t_end, t_busy, t_exp, e_ph, e_mem, e_fios, k;
      logic e_err;
      dl = 10; dc = 20; ds = 5;
      pulse_start(n0);
      repeat (4) @(negedge clock_i);
      start_i = 1'b1; @(negedge clock_i); start_i = 1'b0;
      k = 0;
      while (!fios_start_o && k < 100) begin @(negedge clock_i); k++; end
      repeat (5) @(negedge clock_i);
      stray_store = 1'b1; @(negedge clock_i); stray_store = 1'b0;
      wait_end(t_end, t_busy);
      predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
      checks += 2;
      if (t_end !== t_exp) begin errors++; $display("FAIL stray_latency: got %0d want %0d", t_end - n0, t_exp - n0); end
      if (done_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL stray_flags: got done=%b err=%b want 1/0", done_o, error_o); end
      repeat (10) @(negedge clock_i);
      pulse_start(n1);
      checks += 2;
      if (done_o !== 1'b0) begin errors++; $display("FAIL restart_clear: got %b want 0", done_o); end
      if (busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy_o); end
      wait_end(t_end, t_busy);
      repeat (80) @(negedge clock_i);
   endtask

   task automatic test_reset_midrun;
      int n0, t_end, t_busy, t_exp, e_ph, e_mem, e_fios, k, m0, f0;
      logic e_err;
      dl = 2; dc = 2; ds = 30;
      pulse_start(n0);
      k = 0;
      while (!mem_load_store_o && k < 200) begin @(negedge clock_i); k++; end
      repeat (3) @(negedge clock_i);
      reset_ni = 1'b0;
      #1;
      checks += 5;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy_o); end
      if (host_bram_sel_o !== 1'b1) begin errors++; $display("FAIL arst_hostsel: got %b want 1", host_bram_sel_o); end
      if (mem_load_store_o !== 1'b0) begin errors++; $display("FAIL arst_ls: got %b want 0", mem_load_store_o); end
      if (done_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL arst_flags: got done=%b err=%b want 0/0", done_o, error_o); end
      if (mem_start_o !== 1'b0 || fios_start_o !== 1'b0) begin errors++; $display("FAIL arst_starts: got %b/%b want 0/0", mem_start_o, fios_start_o); end
      @(negedge clock_i);
      reset_ni = 1'b1;
      repeat (80) @(negedge clock_i);
      m0 = n_mem; f0 = n_fios;
      dl = 3; dc = 3; ds = 3;
      pulse_start(n0);
      wait_end(t_end, t_busy);
      predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
      repeat (3) @(negedge clock_i);
      checks += 3;
      if (t_end !== t_exp || done_o !== 1'b1) begin errors++; $display("FAIL arst_rerun: got t=%0d done=%b want t=%0d done=1", t_end - n0, done_o, t_exp - n0); end
      if (n_mem - m0 != 2) begin errors++; $display("FAIL arst_rerun_mem: got %0d want 2", n_mem - m0); end
      if (n_fios - f0 != 1) begin errors++; $display("FAIL arst_rerun_fios: got %0d want 1", n_fios - f0); end
      repeat (80) @(negedge clock_i);
   endtask

   task automatic test_random;
      int n0, t_end, t_busy, t_exp, e_ph, e_mem, e_fios, m0, f0, sel, v;
      logic e_err;
      for (int r = 0; r < 10; r++) begin
         dl = $urandom_range(1, 30); dc = $urandom_range(1, 30); ds = $urandom_range(1, 30);
         sel = $urandom_range(0, 4);
         v   = $urandom_range(0, 2);
         v   = (v == 0) ? 0 : ((v == 1) ? TMO : TMO + 1);
         if (sel == 0) dl = v; else if (sel == 1) dc = v; else if (sel == 2) ds = v;
         m0 = n_mem; f0 = n_fios;
         pulse_start(n0);
         wait_end(t_end, t_busy);
         predict(n0, dl, dc, ds, t_exp, e_err, e_ph, e_mem, e_fios);
         repeat (3) @(negedge clock_i);
         checks += 6;
         if (t_end !== t_exp) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d (d=%0d/%0d/%0d)", r, t_end - n0, t_exp - n0, dl, dc, ds); end
         if (error_o !== e_err || done_o !== !e_err) begin errors++; $display("FAIL rnd%0d_flags: got done=%b err=%b want err=%b", r, done_o, error_o, e_err); end
         if (int'(err_phase_o) != e_ph) begin errors++; $display("FAIL rnd%0d_phase: got %0d want %0d", r, err_phase_o, e_ph); end
         if (n_mem - m0 != e_mem) begin errors++; $display("FAIL rnd%0d_mem: got %0d want %0d", r, n_mem - m0, e_mem); end
         if (n_fios - f0 != e_fios) begin errors++; $display("FAIL rnd%0d_fios: got %0d want %0d", r, n_fios - f0, e_fios); end
         if (t_busy !== t_exp - 1) begin errors++; $display("FAIL rnd%0d_busy_fall: got %0d want %0d", r, t_busy - n0, t_exp - 1 - n0); end
         repeat (80) @(negedge clock_i);
      end
   endtask

   initial begin
      repeat (3) @(negedge clock_i);
      test_reset();
      reset_ni = 1'b1;
      repeat (3) @(negedge clock_i);
      test_nominal();
      test_zero_latency();
      test_compute_timeout();
      test_timeout_edge();
      test_stray();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
